// File: rtl/audio_note_sequencer.sv
// Generic synchronous FIFO: DEPTH words of W bits, DEPTH a power of two.
// Latency: a pushed word appears at rdata on the cycle after its push edge.
// Backpressure: none internal; caller pushes when full only together with a pop.
// Ports: clock/reset (sync, active-low), flush, push, pop, wdata -> rdata, count, full, empty.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// Note sequencer: queues note commands and plays them as a square-wave duty value.
// Latency: write into empty FIFO at edge k -> LOAD after k+1 -> amplitude on duty_cycle after k+2.
// Backpressure: none; writes to a full FIFO are dropped (sticky overflow) unless a pop frees a slot.
// Ports: clock, reset (sync, active-low), wr_en/wr_data (amp[31:22], half[21:12], dur[11:0]), abort,
//        duty_cycle, sample_tick, note_done, busy, full, fifo_count, overflow.
module audio_note_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SAMPLE_DIV     = 1042,
  parameter int TICKS_PER_UNIT = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_data,
  input  logic                        abort,
  output logic [9:0]                  duty_cycle,
  output logic                        sample_tick,
  output logic                        note_done,
  output logic                        busy,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(TICKS_PER_UNIT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] div_cnt;
  logic [9:0]    amp;
  logic [9:0]    half;
  logic [11:0]   dur;
  logic [9:0]    half_cnt;
  logic [11:0]   unit_cnt;
  logic [SW-1:0] sub_cnt;
  logic          phase;
  logic          pop;
  logic          push;
  logic          done_nxt;
  logic          fifo_empty;
  logic [31:0]   head;

  // A write is taken when there is room, or when this cycle's pop makes room.
  assign push = wr_en && !abort && (!full || pop);

  sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (wr_data),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (dur == '0) begin
          // Zero-length note retires straight from LOAD.
          done_nxt = 1'b1;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        // Last tick of the last unit: the unit counter is about to reach 0.
        if (sample_tick && sub_cnt <= SW'(1) && unit_cnt <= 12'd1) begin
          done_nxt = 1'b1;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      pop       = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      amp       <= '0;
      half      <= '0;
      dur       <= '0;
      half_cnt  <= '0;
      unit_cnt  <= '0;
      sub_cnt   <= '0;
      phase     <= 1'b0;
      note_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      note_done <= done_nxt;
      if (abort)                      overflow <= 1'b0;
      else if (wr_en && full && !pop) overflow <= 1'b1;
      if (pop) {amp, half, dur} <= head;
      if (state == LOAD) begin
        half_cnt <= half;
        unit_cnt <= dur;
        sub_cnt  <= SW'(TICKS_PER_UNIT);
        phase    <= 1'b1;
      end else if (state == PLAY && sample_tick) begin
        // A count of 1 means the half-period ends on this tick; 0 (rest) holds.
        if (half_cnt == 10'd1) begin
          phase    <= ~phase;
          half_cnt <= half;
        end else if (half_cnt != '0) begin
          half_cnt <= half_cnt - 10'd1;
        end
        if (sub_cnt <= SW'(1)) begin
          sub_cnt <= SW'(TICKS_PER_UNIT);
          if (unit_cnt != '0) unit_cnt <= unit_cnt - 12'd1;
        end else begin
          sub_cnt <= sub_cnt - SW'(1);
        end
      end
    end
  end

  // Divider restarts in LOAD so every note starts on a full sample period.
  always_ff @(posedge clock) begin
    if (!reset || state == LOAD)                div_cnt <= '0;
    else if (div_cnt == DW'(SAMPLE_DIV - 1))    div_cnt <= '0;
    else                                        div_cnt <= div_cnt + DW'(1);
  end

  assign sample_tick = (div_cnt == DW'(SAMPLE_DIV - 1));
  assign busy        = (state != IDLE);
  assign duty_cycle  = (state == PLAY && phase && half != '0) ? amp : 10'd0;
endmodule

// File: tb/tb_audio_note_sequencer.sv
module tb_audio_note_sequencer;
  localparam int FD  = 8;
  localparam int SD  = 4;
  localparam int TPU = 64;
  localparam int CPU_CLKS = SD * TPU;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] wr_data = '0;
  logic [9:0]  duty_cycle;
  logic        sample_tick;
  logic        note_done;
  logic        busy;
  logic        full;
  logic        overflow;
  logic [3:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] notes_q[$];

  always #5 clock = ~clock;

  audio_note_sequencer #(.FIFO_DEPTH(FD), .SAMPLE_DIV(SD), .TICKS_PER_UNIT(TPU)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .abort       (abort),
    .duty_cycle  (duty_cycle),
    .sample_tick (sample_tick),
    .note_done   (note_done),
    .busy        (busy),
    .full        (full),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  function automatic logic [31:0] mk(int a, int h, int d);
    return {a[9:0], h[9:0], d[11:0]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bit found;
    reset = 1'b0; wr_en = 1'b1; wr_data = mk(100, 1, 1);
    step(); step();
    wr_en = 1'b0;
    checks++; if (duty_cycle !== 10'd0) begin errors++; $display("FAIL rst_duty got %0d want 0", duty_cycle); end
    checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", sample_tick); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", note_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    reset = 1'b1;
    // sample_tick period
    found = 1'b0;
    for (int i = 0; i < 2 * SD && !found; i++) begin step(); if (sample_tick) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL tick_seen got none want pulse within %0d", 2 * SD); end
    for (int n = 1; n <= 3 * SD; n++) begin
      step();
      checks++; if (sample_tick !== ((n % SD) == 0)) begin errors++; $display("FAIL tick_period n=%0d got %b want %b", n, sample_tick, (n % SD) == 0); end
    end
    // reset in the middle of a playing note
    wr_en = 1'b1; wr_data = mk(500, 1023, 5); step(); wr_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin step(); if (duty_cycle == 10'd500) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL rst_play_start got %0d want 500", duty_cycle); end
    reset = 1'b0; wr_en = 1'b1; wr_data = mk(77, 1, 1);
    step();
    reset = 1'b1; wr_en = 1'b0;
    checks++; if (duty_cycle !== 10'd0) begin errors++; $display("FAIL midrst_duty got %0d want 0", duty_cycle); end
    checks++; if (sample_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b want 0", sample_tick); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", note_done); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (note_done || busy) found = 1'b1; end
    checks++; if (found) begin errors++; $display("FAIL midrst_quiet got activity want none"); end
  endtask

  // Builds the expected per-cycle trace from note rules, then streams notes_q in
  // (first entry at edge k, then one per cycle) and compares every cycle from k+1.
  task automatic run_notes(string name);
    int exp_duty[$];
    bit exp_done[$];
    bit exp_busy[$];
    bit pend;
    pend = 1'b0;
    foreach (notes_q[i]) begin
      int a, h, d;
      a = int'(notes_q[i][31:22]);
      h = int'(notes_q[i][21:12]);
      d = int'(notes_q[i][11:0]);
      exp_duty.push_back(0); exp_done.push_back(pend); exp_busy.push_back(1'b1);
      for (int j = 0; j < d * CPU_CLKS; j++) begin
        exp_duty.push_back((h != 0 && ((j / (SD * h)) % 2) == 0) ? a : 0);
        exp_done.push_back(1'b0); exp_busy.push_back(1'b1);
      end
      pend = 1'b1;
    end
    exp_duty.push_back(0); exp_done.push_back(pend); exp_busy.push_back(1'b0);
    for (int i = 0; i < 3; i++) begin exp_duty.push_back(0); exp_done.push_back(1'b0); exp_busy.push_back(1'b0); end

    wr_en = 1'b1; wr_data = notes_q[0];
    step();
    for (int t = 0; t < exp_duty.size(); t++) begin
      if (t + 1 < notes_q.size()) begin wr_en = 1'b1; wr_data = notes_q[t + 1]; end
      else wr_en = 1'b0;
      step();
      checks++; if (duty_cycle !== 10'(exp_duty[t])) begin errors++; $display("FAIL %s_duty t=%0d got %0d want %0d", name, t, duty_cycle, exp_duty[t]); end
      checks++; if (note_done !== exp_done[t]) begin errors++; $display("FAIL %s_done t=%0d got %b want %b", name, t, note_done, exp_done[t]); end
      checks++; if (busy !== exp_busy[t]) begin errors++; $display("FAIL %s_busy t=%0d got %b want %b", name, t, busy, exp_busy[t]); end
    end
    wr_en = 1'b0;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL %s_count_end got %0d want 0", name, fifo_count); end
  endtask

  task automatic test_single_note();
    notes_q.delete();
    notes_q.push_back(mk(300, 2, 1));
    run_notes("single");
  endtask

  task automatic test_rest_zero();
    notes_q.delete();
    notes_q.push_back(mk(611, 0, 1));
    notes_q.push_back(mk(222, 5, 0));
    run_notes("rest_zero");
  endtask

  task automatic test_random_notes();
    for (int b = 0; b < 4; b++) begin
      int n;
      n = $urandom_range(2, FD);
      notes_q.delete();
      for (int i = 0; i < n; i++)
        notes_q.push_back(mk($urandom_range(0, 1023), $urandom_range(0, 3), $urandom_range(0, 2)));
      run_notes("random");
    end
  endtask

  task automatic test_wrap();
    int dones;
    int maxc;
    dones = 0; maxc = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = mk(i + 1, 1, 0);
      step();
      if (note_done) dones++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); if (note_done) dones++; end
    checks++; if (dones != 20) begin errors++; $display("FAIL wrap_dones got %0d want 20", dones); end
    checks++; if (maxc != 1) begin errors++; $display("FAIL wrap_maxcount got %0d want 1", maxc); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b want 0", overflow); end
  endtask

  // Leaves the FSM draining toward a dur=4095 note with overflow set.
  task automatic test_overflow();
    bit found;
    wr_en = 1'b1; wr_data = mk(700, 3, 1);
    step();
    for (int i = 0; i < FD; i++) begin
      wr_data = mk(40 + i, 1, (i == 5) ? 4095 : 0);
      step();
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_fill_count got %0d want 8", fifo_count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_fill_full got %b want 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_fill_ovf got %b want 0", overflow); end
    wr_data = mk(999, 9, 9);
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_ninth_ovf got %b want 1", overflow); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_ninth_count got %0d want 8", fifo_count); end
    // Keep writing until the playing note retires: only the write alongside the pop lands.
    wr_data = mk(11, 1, 0);
    found = 1'b0;
    for (int i = 0; i < 2 * CPU_CLKS && !found; i++) begin step(); if (note_done) found = 1'b1; end
    wr_en = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL ovf_retire got none want note_done"); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_popwrite_count got %0d want 8", fifo_count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_popwrite_full got %b want 1", full); end
  endtask

  task automatic test_abort();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin step(); if (fifo_count == 4'd3) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL abort_setup got count %0d want 3", fifo_count); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (duty_cycle !== 10'd45) begin errors++; $display("FAIL abort_pre_duty got %0d want 45", duty_cycle); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL abort_pre_ovf got %b want 1", overflow); end
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL abort_pre_count got %0d want 3", fifo_count); end
    abort = 1'b1; wr_en = 1'b1; wr_data = mk(5, 5, 5);
    step();
    abort = 1'b0; wr_en = 1'b0;
    checks++; if (duty_cycle !== 10'd0) begin errors++; $display("FAIL abort_duty got %0d want 0", duty_cycle); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL abort_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL abort_full got %b want 0", full); end
    checks++; if (note_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", note_done); end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (note_done || busy || fifo_count != 4'd0) found = 1'b1; end
    checks++; if (found) begin errors++; $display("FAIL abort_quiet got activity want none"); end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_rest_zero();
    test_random_notes();
    test_wrap();
    test_overflow();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
